// File: rtl/rr_grant_sched_if.sv
// Handshake bundle between requesters, the grant consumer and rr_grant_sched.
// The scheduler sits on the slave side; the master side drives requests and acks.
interface rr_grant_sched_if #(
   parameter int LINES = 16,
   parameter int WIDTH = $clog2(LINES)
);
   logic [LINES-1:0] req;
   logic             gnt_ready;
   logic             done;
   logic [LINES-1:0] gnt_onehot;
   logic [WIDTH-1:0] gnt_idx;
   logic             gnt_valid;
   logic             busy;
   logic             timeout_err;

   modport master (
      output req, gnt_ready, done,
      input  gnt_onehot, gnt_idx, gnt_valid, busy, timeout_err
   );

   modport slave (
      input  req, gnt_ready, done,
      output gnt_onehot, gnt_idx, gnt_valid, busy, timeout_err
   );
endinterface

// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler: IDLE picks a winner from ptr upward, OFFER holds it
// until acked, BUSY holds the resource until done or the watchdog forces release.
module rr_grant_sched #(
   parameter int LINES   = 16,
   parameter int WIDTH   = $clog2(LINES),
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   rr_grant_sched_if.slave    bus
);
   typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

   typedef struct packed {
      logic [LINES-1:0] onehot;
      logic [WIDTH-1:0] idx;
   } gnt_t;

   localparam logic [15:0]      TO   = 16'(TIMEOUT);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(LINES-1);
   localparam logic [WIDTH:0]   NL   = (WIDTH+1)'(LINES);

   state_t           state_q, state_d;
   gnt_t             gnt_q, gnt_d;
   logic [WIDTH-1:0] ptr_q, ptr_d;
   logic [15:0]      wdog_q, wdog_d, wdog_inc;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             terr_q, terr_d;

   logic             win_found;
   logic [WIDTH-1:0] win_idx;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] cand;

   // Rotating priority search; sum stays below 2*LINES so one subtract wraps it.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      sum       = '0;
      cand      = '0;
      for (int i = 0; i < LINES; i++) begin
         sum = {1'b0, ptr_q} + (WIDTH+1)'(i);
         if (sum >= NL) sum = sum - NL;
         cand = sum[WIDTH-1:0];
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      ptr_d    = ptr_q;
      wdog_d   = wdog_q;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      terr_d   = 1'b0;
      wdog_inc = (wdog_q == TO) ? wdog_q : wdog_q + 16'd1;
      unique case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (win_found) begin
               state_d             = OFFER;
               gnt_d.onehot[win_idx] = 1'b1;
               gnt_d.idx           = win_idx;
               valid_d             = 1'b1;
            end
         end
         OFFER: begin
            if (bus.gnt_ready) begin
               state_d = BUSY;
               busy_d  = 1'b1;
               wdog_d  = '0;
            end else begin
               valid_d = 1'b1;
            end
         end
         BUSY: begin
            // done wins over a coincident watchdog expiry, so no error then
            if (bus.done || wdog_inc == TO) begin
               state_d = IDLE;
               gnt_d   = '0;
               ptr_d   = (gnt_q.idx == LAST) ? '0 : gnt_q.idx + WIDTH'(1);
               wdog_d  = '0;
               terr_d  = !bus.done;
            end else begin
               busy_d = 1'b1;
               wdog_d = wdog_inc;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         wdog_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         wdog_q  <= wdog_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         terr_q  <= terr_d;
      end
   end

   assign bus.gnt_onehot  = gnt_q.onehot;
   assign bus.gnt_idx     = gnt_q.idx;
   assign bus.gnt_valid   = valid_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed bench for rr_grant_sched (LINES=16, TIMEOUT=4); outputs are packed as
// {gnt_valid, busy, timeout_err, gnt_idx, gnt_onehot} and compared to hand values.
module tb_rr_grant_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [22:0] obs, exp_v;

   rr_grant_sched_if #(.LINES(16), .WIDTH(4)) bus();

   rr_grant_sched #(.LINES(16), .WIDTH(4), .TIMEOUT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign obs = {bus.gnt_valid, bus.busy, bus.timeout_err, bus.gnt_idx, bus.gnt_onehot};

   function automatic logic [22:0] mk(input logic v, input logic b, input logic t,
                                      input logic [3:0] i, input logic [15:0] oh);
      return {v, b, t, i, oh};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.req = '0; bus.gnt_ready = 1'b0; bus.done = 1'b0;
      #12;
      exp_v = mk(0, 0, 0, 4'd0, 16'h0000); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL reset_held: got %h want %h", obs, exp_v); end
      tick;
      rst_n = 1'b1;
      exp_v = mk(0, 0, 0, 4'd0, 16'h0000); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL reset_release: got %h want %h", obs, exp_v); end
      tick;
      exp_v = mk(0, 0, 0, 4'd0, 16'h0000); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL idle_no_req: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_single;
      bus.gnt_ready = 1'b1;
      bus.req = 16'h0001;
      tick;
      exp_v = mk(1, 0, 0, 4'd0, 16'h0001); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL single_offer: got %h want %h", obs, exp_v); end
      bus.req = '0;
      for (int c = 1; c <= 3; c++) begin
         tick;
         exp_v = mk(0, 1, 0, 4'd0, 16'h0001); n_cmp++;
         if (obs !== exp_v) begin n_bad++; $display("FAIL single_busy%0d: got %h want %h", c, obs, exp_v); end
      end
      bus.done = 1'b1;
      tick;
      bus.done = 1'b0;
      exp_v = mk(0, 0, 0, 4'd0, 16'h0000); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL single_release: got %h want %h", obs, exp_v); end
      bus.req = 16'hFFFF;
      tick;
      exp_v = mk(1, 0, 0, 4'd1, 16'h0002); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL single_ptr1: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_wrap;
      logic [3:0]  i;
      logic [15:0] oh;
      // async reset while an offer is pending
      #2 rst_n = 1'b0;
      #1;
      exp_v = mk(0, 0, 0, 4'd0, 16'h0000); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL reset_mid_offer: got %h want %h", obs, exp_v); end
      #1 rst_n = 1'b1;
      bus.req = 16'hFFFF;
      for (int k = 0; k < 17; k++) begin
         i  = 4'(k % 16);
         oh = 16'h0001 << i;
         tick;
         exp_v = mk(1, 0, 0, i, oh); n_cmp++;
         if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_offer%0d: got %h want %h", k, obs, exp_v); end
         tick;
         exp_v = mk(0, 1, 0, i, oh); n_cmp++;
         if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_busy%0d: got %h want %h", k, obs, exp_v); end
         bus.done = 1'b1;
         if (k == 16) bus.req = '0;
         tick;
         bus.done = 1'b0;
         exp_v = mk(0, 0, 0, 4'd0, 16'h0000); n_cmp++;
         if (obs !== exp_v) begin n_bad++; $display("FAIL wrap_idle%0d: got %h want %h", k, obs, exp_v); end
      end
   endtask

   task automatic test_wrap_search;
      bus.req = 16'h0010;
      tick;
      exp_v = mk(1, 0, 0, 4'd4, 16'h0010); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL ws_first: got %h want %h", obs, exp_v); end
      tick;
      bus.done = 1'b1; bus.req = 16'h0011;
      tick;
      bus.done = 1'b0;
      exp_v = mk(0, 0, 0, 4'd0, 16'h0000); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL ws_idle: got %h want %h", obs, exp_v); end
      tick;
      exp_v = mk(1, 0, 0, 4'd0, 16'h0001); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL ws_wrap0: got %h want %h", obs, exp_v); end
      tick;
      bus.done = 1'b1;
      tick;
      bus.done = 1'b0;
      tick;
      exp_v = mk(1, 0, 0, 4'd4, 16'h0010); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL ws_next4: got %h want %h", obs, exp_v); end
      tick;
      bus.done = 1'b1; bus.req = '0;
      tick;
      bus.done = 1'b0;
   endtask

   task automatic test_offer_hold;
      bus.gnt_ready = 1'b0;
      bus.req = 16'h0100;
      tick;
      exp_v = mk(1, 0, 0, 4'd8, 16'h0100); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL hold_offer: got %h want %h", obs, exp_v); end
      bus.req = '0; bus.done = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick;
         exp_v = mk(1, 0, 0, 4'd8, 16'h0100); n_cmp++;
         if (obs !== exp_v) begin n_bad++; $display("FAIL hold_stable%0d: got %h want %h", c, obs, exp_v); end
      end
      bus.done = 1'b0; bus.gnt_ready = 1'b1; bus.req = 16'h0002;
      tick;
      exp_v = mk(0, 1, 0, 4'd8, 16'h0100); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL hold_ack: got %h want %h", obs, exp_v); end
      bus.done = 1'b1; bus.req = '0;
      tick;
      tick;
      bus.done = 1'b0;
      exp_v = mk(0, 0, 0, 4'd0, 16'h0000); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL done_in_idle: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_timeout;
      bus.req = 16'h0001;
      tick;
      exp_v = mk(1, 0, 0, 4'd0, 16'h0001); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL to_offer: got %h want %h", obs, exp_v); end
      bus.req = '0;
      for (int c = 1; c <= 4; c++) begin
         tick;
         exp_v = mk(0, 1, 0, 4'd0, 16'h0001); n_cmp++;
         if (obs !== exp_v) begin n_bad++; $display("FAIL to_busy%0d: got %h want %h", c, obs, exp_v); end
      end
      tick;
      exp_v = mk(0, 0, 1, 4'd0, 16'h0000); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL to_pulse: got %h want %h", obs, exp_v); end
      tick;
      exp_v = mk(0, 0, 0, 4'd0, 16'h0000); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL to_pulse_end: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_done_vs_timeout;
      bus.req = 16'h0002;
      tick;
      exp_v = mk(1, 0, 0, 4'd1, 16'h0002); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL dt_offer: got %h want %h", obs, exp_v); end
      bus.req = '0;
      repeat (4) tick;
      exp_v = mk(0, 1, 0, 4'd1, 16'h0002); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL dt_busy4: got %h want %h", obs, exp_v); end
      bus.done = 1'b1;
      tick;
      bus.done = 1'b0;
      exp_v = mk(0, 0, 0, 4'd0, 16'h0000); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL dt_no_err: got %h want %h", obs, exp_v); end
   endtask

   task automatic test_reset_mid_busy;
      bus.req = 16'h0004;
      tick;
      bus.req = '0;
      tick;
      exp_v = mk(0, 1, 0, 4'd2, 16'h0004); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL rb_busy: got %h want %h", obs, exp_v); end
      #3 rst_n = 1'b0;
      #1;
      exp_v = mk(0, 0, 0, 4'd0, 16'h0000); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL rb_async: got %h want %h", obs, exp_v); end
      #2 rst_n = 1'b1;
      bus.req = 16'h8000;
      tick;
      exp_v = mk(1, 0, 0, 4'd15, 16'h8000); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL rb_grant15: got %h want %h", obs, exp_v); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_wrap;
      test_wrap_search;
      test_offer_hold;
      test_timeout;
      test_done_vs_timeout;
      test_reset_mid_busy;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rr_grant_sched.md
RR_GRANT_SCHED -- requirements
Module: rr_grant_sched

Interface
REQ-001 Parameter LINES, default 16: number of requesters.
REQ-002 Parameter WIDTH, default $clog2(LINES): width of the binary grant index.
REQ-003 Parameter TIMEOUT, default 255: maximum BUSY cycles before a forced release; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 req  input  LINES  request vector; bit i set means requester i wants the shared resource.
REQ-007 gnt_ready  input  1  consumer accepts the offered grant.
REQ-008 done  input  1  single-cycle pulse from the grant holder; releases the resource.
REQ-009 gnt_onehot  output  LINES  registered one-hot grant vector; all zero when nothing is granted.
REQ-010 gnt_idx  output  WIDTH  registered binary index of the set bit in gnt_onehot; 0 when nothing is granted.
REQ-011 gnt_valid  output  1  grant offer is pending (OFFER state).
REQ-012 busy  output  1  resource held (BUSY state).
REQ-013 timeout_err  output  1  one-cycle pulse on a forced release.

Function
REQ-014 FSM states SHALL be IDLE, OFFER and BUSY; all outputs SHALL be registered.
REQ-015 IDLE with req != 0: SHALL select the first set req bit at or above pointer ptr, scanning upward and wrapping from LINES-1 to 0.
REQ-016 IDLE with req != 0: SHALL load gnt_onehot/gnt_idx with that winner and enter OFFER on the next edge; gnt_valid SHALL be 1 the cycle after req is first seen (1-cycle latency).
REQ-017 IDLE with req == 0: SHALL stay in IDLE with gnt_onehot = 0, gnt_idx = 0, gnt_valid = 0 and busy = 0.
REQ-018 OFFER: gnt_onehot, gnt_idx and gnt_valid SHALL stay stable until gnt_ready = 1.
REQ-019 OFFER: changes on req SHALL be ignored; the winner is never withdrawn.
REQ-020 OFFER with gnt_ready = 1: SHALL enter BUSY on the next edge; gnt_valid -> 0, busy -> 1, gnt_onehot/gnt_idx held.
REQ-021 BUSY: a watchdog counter SHALL be cleared on entry and SHALL increment each BUSY cycle, saturating at TIMEOUT.
REQ-022 BUSY with done = 1: SHALL return to IDLE on the next edge, clear gnt_onehot/gnt_idx and busy, and set ptr = (gnt_idx + 1) mod LINES.
REQ-023 BUSY, done not seen and counter reaching TIMEOUT: SHALL force the same release as REQ-022 and pulse timeout_err for exactly one cycle.
REQ-024 done and the timeout in the same cycle: done SHALL take priority; no timeout_err.
REQ-025 done asserted in IDLE or OFFER SHALL be ignored.
REQ-026 Minimum spacing: done at cycle N -> IDLE at N+1 -> next gnt_valid at N+2.
REQ-027 ptr SHALL be a WIDTH-bit register that never holds a value >= LINES.
REQ-028 Wrap: with LINES not a power of two, ptr SHALL wrap from LINES-1 to 0.
REQ-029 Fairness: a continuously asserted request SHALL be granted within LINES grant cycles.
REQ-030 gnt_idx SHALL always equal the binary encoding of gnt_onehot; gnt_onehot SHALL never have more than one bit set.

Reset
REQ-031 rst_n = 0 SHALL immediately force: state IDLE, ptr = 0, watchdog = 0, all outputs 0.
REQ-032 This SHALL hold regardless of the clock, including mid-OFFER or mid-BUSY.
REQ-033 After rst_n deasserts, the first grant SHALL be evaluated on the first rising edge with rst_n = 1.

Verification
REQ-034 Scenario: reset; req = 16'h0001; gnt_ready held 1; done 3 cycles after busy -> gnt_valid one cycle after req, gnt_idx = 0, gnt_onehot = 16'h0001, busy for 3 cycles, then ptr = 1.
REQ-035 Scenario: req = 16'hFFFF held constant; each grant acked and done-pulsed -> gnt_idx sequence 0,1,2,...,15,0 (wrap).
REQ-036 Scenario: ptr = 5, req = 16'h0011 -> grant idx 0 (wrap search); next grant idx 4.
REQ-037 Scenario: TIMEOUT = 4, grant accepted, done never sent -> timeout_err pulses once after 4 BUSY cycles, busy drops, gnt_onehot = 0.
REQ-038 Scenario: in OFFER with gnt_ready = 0, deassert the winner's req -> gnt_onehot unchanged until ack; done in OFFER ignored.
REQ-039 Scenario: rst_n pulsed low mid-BUSY between clock edges -> outputs 0 immediately; next req = 16'h8000 grants idx 15 from ptr = 0.
